// File: rtl/timer_6502.sv
// rtl/timer_6502.sv - 16-bit prescaled interval timer with level IRQ for the 6502 SoC bus
// Optional macro TIMER_TOGGLE_EN adds the tout output, toggled on terminal count when CTRL[3]=TOE.
module timer_6502 #(
  parameter logic [15:0] LOAD_RST = 16'hFFFF,
  parameter int          PS_W     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       we,
  input  logic [1:0] rs,
  input  logic [7:0] din,
  output logic [7:0] dout,
`ifdef TIMER_TOGGLE_EN
  output logic       tout,
`endif
  output logic       irq
);

  logic [7:0]      load_lo, load_hi, hi_shadow, rd_data;
  logic [15:0]     cnt;
  logic [PS_W-1:0] ps, pre;
  logic            en, auto_rl, ie, toe, tc;
  logic            wr, lo_wr, hi_wr, ctrl_wr, stat_clr, lo_rd;
  logic            tick, live_tick, tc_hit;

  always_comb begin
    wr        = cs & we;
    lo_wr     = wr & (rs == 2'd0);
    hi_wr     = wr & (rs == 2'd1);
    ctrl_wr   = wr & (rs == 2'd2);
    stat_clr  = wr & (rs == 2'd3) & din[7];
    lo_rd     = cs & ~we & (rs == 2'd0);
    tick      = en & (pre == ps);
    // A HI load or a CTRL write that stops the timer swallows the tick.
    live_tick = tick & ~hi_wr & ~(ctrl_wr & ~din[0]);
    tc_hit    = live_tick & (cnt == 16'h0000);
    rd_data   = 8'h00;
    case (rs)
      2'd0:    rd_data = cnt[7:0];
      2'd1:    rd_data = hi_shadow;
      2'd2:    rd_data = {ps, toe, ie, auto_rl, en};
      default: rd_data = {tc, 6'b000000, en};
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_lo   <= LOAD_RST[7:0];
      load_hi   <= LOAD_RST[15:8];
      cnt       <= LOAD_RST;
      hi_shadow <= LOAD_RST[15:8];
      en        <= 1'b0;
      auto_rl   <= 1'b0;
      ie        <= 1'b0;
      ps        <= '0;
      pre       <= '0;
      tc        <= 1'b0;
      dout      <= 8'h00;
      irq       <= 1'b0;
    end else begin
      dout <= rd_data;
      irq  <= tc & ie;
      if (lo_wr) load_lo <= din;
      if (hi_wr) load_hi <= din;
      if (lo_rd) hi_shadow <= cnt[15:8];

      if (hi_wr || !en || tick || (ctrl_wr && !din[0])) pre <= '0;
      else                                              pre <= pre + 1'b1;

      if (hi_wr) begin
        cnt <= {din, load_lo};
      end else if (live_tick) begin
        if (cnt != 16'h0000) cnt <= cnt - 16'd1;
        else if (auto_rl)    cnt <= {load_hi, load_lo};
      end

      // Terminal count beats a simultaneous clear request.
      if (tc_hit)        tc <= 1'b1;
      else if (stat_clr) tc <= 1'b0;

      if (ctrl_wr) begin
        en      <= din[0];
        auto_rl <= din[1];
        ie      <= din[2];
        ps      <= din[3+PS_W:4];
      end else if (tc_hit && !auto_rl) begin
        en <= 1'b0;
      end
    end
  end

`ifdef TIMER_TOGGLE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      toe  <= 1'b0;
      tout <= 1'b0;
    end else begin
      if (ctrl_wr)       toe  <= din[3];
      if (tc_hit && toe) tout <= ~tout;
    end
  end
`else
  assign toe = 1'b0;
`endif

endmodule

// File: tb/tb_timer_6502.sv
// tb/tb_timer_6502.sv - self-checking bench for timer_6502: vector table, corner sequences, random vs model
`timescale 1ns/1ps
module tb_timer_6502;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cs = 1'b0, we = 1'b0;
  logic [1:0] rs = 2'd0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       irq;
`ifdef TIMER_TOGGLE_EN
  logic       tout;
`endif

  always #5 clk = ~clk;

  timer_6502 dut (
    .clk  (clk),
    .rst  (rst),
    .cs   (cs),
    .we   (we),
    .rs   (rs),
    .din  (din),
    .dout (dout),
`ifdef TIMER_TOGGLE_EN
    .tout (tout),
`endif
    .irq  (irq)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check8(string name, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  typedef struct {
    bit         rst_a;
    bit         cs;
    bit         we;
    logic [1:0] rs;
    logic [7:0] din;
    logic [7:0] exp_dout;
    bit         exp_irq;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(int n, bit r, bit c, bit w, logic [1:0] s, logic [7:0] d,
                              logic [7:0] ed, bit ei);
    vec_t v;
    v = '{r, c, w, s, d, ed, ei};
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endfunction

  // Called at a negedge; drives one cycle and compares results half a cycle after the posedge.
  task automatic apply(vec_t v, string name, bit chk);
    rst = ~v.rst_a; cs = v.cs; we = v.we; rs = v.rs; din = v.din;
    @(posedge clk);
    @(negedge clk);
    if (chk) begin
      check8({name, " dout"}, dout, v.exp_dout);
      check8({name, " irq"}, {7'b0, irq}, {7'b0, v.exp_irq});
    end
  endtask

  function automatic vec_t mk(bit r, bit c, bit w, logic [1:0] s, logic [7:0] d, logic [7:0] ed, bit ei);
    vec_t v;
    v = '{r, c, w, s, d, ed, ei};
    return v;
  endfunction

  // Reference model: register-level view of the timer, advanced once per clock.
  logic [15:0] m_cnt, m_load;
  logic [7:0]  m_shadow, m_dout;
  logic [3:0]  m_ps;
  int          m_pre;
  bit          m_en, m_auto, m_ie, m_toe, m_tc, m_irq, m_tout;

  task automatic m_reset();
    m_cnt = 16'hFFFF; m_load = 16'hFFFF; m_shadow = 8'hFF; m_dout = 8'h00;
    m_ps = 4'd0; m_pre = 0; m_en = 0; m_auto = 0; m_ie = 0; m_toe = 0;
    m_tc = 0; m_irq = 0; m_tout = 0;
  endtask

  task automatic m_step(bit c, bit w, logic [1:0] s, logic [7:0] d);
    bit wr, tick, fire, hit, stop_wr;
    logic [7:0] rv;
    wr = c && w;
    case (s)
      2'd0: rv = m_cnt[7:0];
      2'd1: rv = m_shadow;
      2'd2: rv = {m_ps, m_toe, m_ie, m_auto, m_en};
      default: rv = {m_tc, 6'b0, m_en};
    endcase
    tick    = m_en && (m_pre == int'(m_ps));
    stop_wr = wr && s == 2'd2 && !d[0];
    fire    = tick && !(wr && s == 2'd1) && !stop_wr;
    hit     = fire && m_cnt == 16'd0;
    m_irq   = m_tc && m_ie;
    m_dout  = rv;
    if (c && !w && s == 2'd0) m_shadow = m_cnt[15:8];
    if (hit && m_toe) m_tout = !m_tout;
    m_pre = ((wr && s == 2'd1) || !m_en || tick || stop_wr) ? 0 : (m_pre + 1) % 16;
    if (wr && s == 2'd1) m_cnt = {d, m_load[7:0]};
    else if (fire) m_cnt = (m_cnt != 0) ? m_cnt - 16'd1 : (m_auto ? m_load : 16'd0);
    if (hit) begin
      m_tc = 1;
      if (!m_auto) m_en = 0;
    end else if (wr && s == 2'd3 && d[7]) begin
      m_tc = 0;
    end
    if (wr && s == 2'd0) m_load[7:0] = d;
    if (wr && s == 2'd1) m_load[15:8] = d;
    if (wr && s == 2'd2) begin
      m_en = d[0]; m_auto = d[1]; m_ie = d[2]; m_ps = d[7:4];
`ifdef TIMER_TOGGLE_EN
      m_toe = d[3];
`endif
    end
  endtask

  initial begin
    bit c, w;
    logic [1:0] s;
    logic [7:0] d;

    // Reset and register readback
    add(1, 1, 0, 0, 2'd0, 8'h00, 8'h00, 0);
    add(1, 0, 1, 0, 2'd0, 8'h00, 8'hFF, 0);
    add(1, 0, 1, 0, 2'd1, 8'h00, 8'hFF, 0);
    add(1, 0, 1, 0, 2'd2, 8'h00, 8'h00, 0);
    add(1, 0, 1, 0, 2'd3, 8'h00, 8'h00, 0);
    // load=3, PS=0, AUTO+IE+EN: TC every 4 clocks, cleared by STAT write
    add(1, 0, 1, 1, 2'd0, 8'h03, 8'hFF, 0);
    add(1, 0, 1, 1, 2'd1, 8'h00, 8'hFF, 0);
    add(1, 0, 1, 1, 2'd2, 8'h07, 8'h00, 0);
    add(4, 0, 0, 0, 2'd3, 8'h00, 8'h01, 0);
    add(1, 0, 0, 0, 2'd3, 8'h00, 8'h81, 1);
    add(1, 0, 1, 1, 2'd3, 8'h80, 8'h81, 1);
    add(2, 0, 0, 0, 2'd3, 8'h00, 8'h01, 0);
    add(1, 0, 0, 0, 2'd3, 8'h00, 8'h81, 1);
    // One-shot, load=2, PS=3: TC after 12 clocks, EN drops, no further TC
    add(1, 1, 0, 0, 2'd0, 8'h00, 8'h00, 0);
    add(1, 0, 1, 1, 2'd0, 8'h02, 8'hFF, 0);
    add(1, 0, 1, 1, 2'd1, 8'h00, 8'hFF, 0);
    add(1, 0, 1, 1, 2'd2, 8'h35, 8'h00, 0);
    add(12, 0, 0, 0, 2'd3, 8'h00, 8'h01, 0);
    add(1, 0, 0, 0, 2'd3, 8'h00, 8'h80, 1);
    add(1, 0, 1, 0, 2'd0, 8'h00, 8'h00, 1);
    add(1, 0, 1, 0, 2'd2, 8'h00, 8'h34, 1);
    add(8, 0, 0, 0, 2'd3, 8'h00, 8'h80, 1);
    // STAT clear on the exact TC cycle: set wins
    add(1, 1, 0, 0, 2'd0, 8'h00, 8'h00, 0);
    add(1, 0, 1, 1, 2'd0, 8'h01, 8'hFF, 0);
    add(1, 0, 1, 1, 2'd1, 8'h00, 8'hFF, 0);
    add(1, 0, 1, 1, 2'd2, 8'h07, 8'h00, 0);
    add(1, 0, 0, 0, 2'd3, 8'h00, 8'h01, 0);
    add(1, 0, 1, 1, 2'd3, 8'h80, 8'h01, 0);
    add(2, 0, 0, 0, 2'd3, 8'h00, 8'h81, 1);

    @(negedge clk);
    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i), 1'b1);

    // Asynchronous reset mid-count while irq is high
    #2 rst = 1'b0;
    #1;
    check8("async_rst dout", dout, 8'h00);
    check8("async_rst irq", {7'b0, irq}, 8'h00);
`ifdef TIMER_TOGGLE_EN
    check8("async_rst tout", {7'b0, tout}, 8'h00);
`endif
    @(negedge clk);
    apply(mk(0, 1, 0, 2'd0, 8'h00, 8'hFF, 0), "post_rst lo", 1'b1);
    apply(mk(0, 1, 0, 2'd2, 8'h00, 8'h00, 0), "post_rst ctrl", 1'b1);

    // HI returns the snapshot taken by the LO read, not the live count
    apply(mk(0, 1, 1, 2'd0, 8'h34, 8'h00, 0), "snap setup", 1'b0);
    apply(mk(0, 1, 1, 2'd1, 8'h12, 8'h00, 0), "snap setup", 1'b0);
    apply(mk(0, 1, 1, 2'd2, 8'h01, 8'h00, 0), "snap setup", 1'b0);
    apply(mk(0, 1, 0, 2'd0, 8'h00, 8'h34, 0), "snap lo", 1'b1);
    for (int k = 0; k < 64; k++) apply(mk(0, 0, 0, 2'd2, 8'h00, 8'h00, 0), "snap wait", 1'b0);
    apply(mk(0, 1, 0, 2'd1, 8'h00, 8'h12, 0), "snap hi", 1'b1);
    apply(mk(0, 1, 0, 2'd0, 8'h00, 8'hF2, 0), "snap lo2", 1'b1);
    apply(mk(0, 1, 0, 2'd1, 8'h00, 8'h11, 0), "snap hi2", 1'b1);

`ifdef TIMER_TOGGLE_EN
    begin
      logic [5:0] pat;
      pat = 6'b100110;
      apply(mk(1, 0, 0, 2'd0, 8'h00, 8'h00, 0), "tog rst", 1'b0);
      apply(mk(0, 1, 1, 2'd0, 8'h01, 8'h00, 0), "tog setup", 1'b0);
      apply(mk(0, 1, 1, 2'd1, 8'h00, 8'h00, 0), "tog setup", 1'b0);
      apply(mk(0, 1, 1, 2'd2, 8'h0B, 8'h00, 0), "tog setup", 1'b0);
      for (int k = 0; k < 6; k++) begin
        apply(mk(0, 0, 0, 2'd2, 8'h00, 8'h00, 0), "tog", 1'b0);
        check8($sformatf("tout%0d", k), {7'b0, tout}, {7'b0, pat[k]});
      end
      #2 rst = 1'b0;
      #1;
      check8("tog rst tout", {7'b0, tout}, 8'h00);
      @(negedge clk);
    end
`endif

    // Randomized bus traffic against the reference model
    apply(mk(1, 0, 0, 2'd0, 8'h00, 8'h00, 0), "rand rst", 1'b0);
    m_reset();
    rst = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      c = ($urandom_range(0, 3) != 0);
      w = ($urandom_range(0, 5) == 0);
      s = 2'($urandom_range(0, 3));
      d = 8'($urandom);
      if (s == 2'd1) d = 8'($urandom_range(0, 1));
      else if (s == 2'd0 && w) d = 8'($urandom_range(0, 15));
      else if (s == 2'd2) d[7:4] = 4'($urandom_range(0, 2));
      cs = c; we = w; rs = s; din = d;
      m_step(c, w, s, d);
      @(posedge clk);
      @(negedge clk);
      check8($sformatf("rand%0d dout", n), dout, m_dout);
      check8($sformatf("rand%0d irq", n), {7'b0, irq}, {7'b0, m_irq});
`ifdef TIMER_TOGGLE_EN
      check8($sformatf("rand%0d tout", n), {7'b0, tout}, {7'b0, m_tout});
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
